// File: rtl/field_alu_pkg.sv
// Shared types and constants for the GF(p) add/sub/mul sequencer.
package field_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN1 = 3'd1,
        S_GAP  = 3'd2,
        S_RUN2 = 3'd3,
        S_CMP  = 3'd4,
        S_HOLD = 3'd5
    } state_e;

    // p = 2^448 - 2^224 - 1 (Curve448 field prime), used by reference models.
    localparam logic [447:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

endpackage

// File: rtl/field_alu_watchdog.sv
// Per-pass cycle watchdog: clear on pass start, counts while enabled,
// flags expiry on the LIMIT-th enabled cycle without a clear.
module field_alu_watchdog
    import field_alu_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign expired = en && (cnt == CNT_W'(LIMIT - 1));

    // Count enabled cycles of the current pass; hold once expired.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/field_alu_seq.sv
// Sequencer for GF(p) add/sub/mul: drives external modular adder and
// multiplier, optionally re-executes each op as an independent check,
// and returns result + tag with error/timeout flags.
module field_alu_seq
    import field_alu_pkg::*;
#(
    parameter int WIDTH          = 448,
    parameter int TAG_W          = 4,
    parameter bit CHECK_EN       = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 add_en,
    output logic                 add_mode,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic                 add_done,
    input  logic [WIDTH-1:0]     add_res,
    output logic                 mul_en,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_error,
    output logic                 out_timeout,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_e             state_q, state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q, r1_q, r2_q;
    logic [TAG_W-1:0]   tag_q;

    logic               accept;
    logic               is_mul;
    logic               unit_done;
    logic [WIDTH-1:0]   unit_res;
    logic               mismatch;
    logic               wd_en, wd_clr, wd_exp;

    // FSM strobes into the datapath
    logic               launch1, launch2, cap1, cap2, drop, fin, hs;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_err, fin_to;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (op_q == OP_MUL);
    // Only the unit owning the current op is listened to.
    assign unit_done = is_mul ? mul_done : add_done;
    assign unit_res  = is_mul ? mul_res : add_res;
    // ADD/SUB check pass inverts the op and must land back on a; MUL just recomputes.
    assign mismatch  = is_mul ? (r2_q != r1_q) : (r2_q != a_q);
    assign wd_en     = ((state_q == S_RUN1) && (op_q != OP_ILL)) || (state_q == S_RUN2);

    field_alu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_exp)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d = state_q;
        launch1 = 1'b0;
        launch2 = 1'b0;
        cap1    = 1'b0;
        cap2    = 1'b0;
        drop    = 1'b0;
        fin     = 1'b0;
        fin_res = '0;
        fin_err = 1'b0;
        fin_to  = 1'b0;
        hs      = 1'b0;
        wd_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN1;
                    launch1 = (in_op != OP_ILL);
                    wd_clr  = 1'b1;
                end
            end
            S_RUN1: begin
                if (op_q == OP_ILL) begin
                    state_d = S_HOLD;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (unit_done) begin
                    cap1 = 1'b1;
                    drop = 1'b1;
                    if (CHECK_EN) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_HOLD;
                        fin     = 1'b1;
                        fin_res = unit_res;
                    end
                end else if (wd_exp) begin
                    drop    = 1'b1;
                    state_d = S_HOLD;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    fin_to  = 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_RUN2;
                launch2 = 1'b1;
                wd_clr  = 1'b1;
            end
            S_RUN2: begin
                if (unit_done) begin
                    cap2    = 1'b1;
                    drop    = 1'b1;
                    state_d = S_CMP;
                end else if (wd_exp) begin
                    drop    = 1'b1;
                    state_d = S_HOLD;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    fin_to  = 1'b1;
                end
            end
            S_CMP: begin
                state_d = S_HOLD;
                fin     = 1'b1;
                fin_res = r1_q;
                fin_err = mismatch;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    hs      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: request latch, registered unit interfaces, pass results, response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready    <= 1'b0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            add_en      <= 1'b0;
            add_mode    <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            mul_en      <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_error   <= 1'b0;
            out_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            in_ready <= (state_d == S_IDLE);

            if (accept) begin
                op_q  <= op_e'(in_op);
                a_q   <= in_a;
                b_q   <= in_b;
                tag_q <= in_tag;
            end

            if (launch1) begin
                if (in_op == OP_MUL) begin
                    mul_en <= 1'b1;
                    mul_a  <= in_a;
                    mul_b  <= in_b;
                end else begin
                    add_en   <= 1'b1;
                    add_mode <= in_op[0];
                    add_a    <= in_a;
                    add_b    <= in_b;
                end
            end

            // Check pass: inverse op for ADD/SUB, swapped operands for MUL.
            if (launch2) begin
                case (op_q)
                    OP_ADD: begin
                        add_en   <= 1'b1;
                        add_mode <= 1'b1;
                        add_a    <= r1_q;
                        add_b    <= b_q;
                    end
                    OP_SUB: begin
                        add_en   <= 1'b1;
                        add_mode <= 1'b0;
                        add_a    <= r1_q;
                        add_b    <= b_q;
                    end
                    OP_MUL: begin
                        mul_en <= 1'b1;
                        mul_a  <= b_q;
                        mul_b  <= a_q;
                    end
                    default: ;
                endcase
            end

            if (drop) begin
                add_en <= 1'b0;
                mul_en <= 1'b0;
            end

            if (cap1) r1_q <= unit_res;
            if (cap2) r2_q <= unit_res;

            if (fin) begin
                out_valid   <= 1'b1;
                out_result  <= fin_res;
                out_tag     <= tag_q;
                out_error   <= fin_err;
                out_timeout <= fin_to;
            end

            if (hs) begin
                out_valid <= 1'b0;
                if (out_error && (err_count != '1))
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_field_alu_seq.sv
// Scoreboard bench for field_alu_seq with behavioural mod-p adder and
// multiplier models of programmable latency.
module tb_field_alu_seq;
    import field_alu_pkg::*;

    localparam int W = 448;
    localparam logic [448:0] PX = {1'b0, P448};

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic [3:0]    in_tag;
    logic          add_en, add_mode, add_done;
    logic [W-1:0]  add_a, add_b, add_res;
    logic          mul_en, mul_done;
    logic [W-1:0]  mul_a, mul_b, mul_res;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_tag;
    logic          out_error, out_timeout;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    field_alu_seq #(
        .WIDTH(W), .TAG_W(4), .CHECK_EN(1'b1), .TIMEOUT_CYCLES(64), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .add_en(add_en), .add_mode(add_mode), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_res(add_res),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_res(mul_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_error(out_error), .out_timeout(out_timeout),
        .err_count(err_count)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] addmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [448:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= PX) s = s - PX;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] submod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [448:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + PX - {1'b0, b};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [448:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= PX) r = r - PX;
            if (b[i]) begin
                r = r + {1'b0, a};
                if (r >= PX) r = r - PX;
            end
        end
        return r[W-1:0];
    endfunction

    // ---------------- unit models ----------------
    int   add_lat = 3, mul_lat = 4;
    int   add_cnt = 0, mul_cnt = 0;
    logic mul_stuck = 1'b0, mul_corrupt = 1'b0;

    always_ff @(posedge clk) begin
        if (!add_en || add_done) add_cnt <= 0;
        else                     add_cnt <= add_cnt + 1;
        if (!mul_en || mul_done) mul_cnt <= 0;
        else                     mul_cnt <= mul_cnt + 1;
    end

    assign add_done = add_en && (add_cnt == add_lat - 1);
    assign mul_done = mul_en && !mul_stuck && (mul_cnt == mul_lat - 1);

    always_comb begin
        add_res = add_mode ? submod(add_a, add_b) : addmod(add_a, add_b);
    end

    // Corruption hits only the swapped (check) pass of the a=2^447,b=3 vector.
    always_comb begin
        mul_res = mulmod(mul_a, mul_b);
        if (mul_corrupt && (mul_a == 448'd3)) mul_res[0] = ~mul_res[0];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   tag;
        logic         err;
        logic         to;
        int           lat;
        time          acc_t;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops on each response handshake, checks hold stability and err_count.
    logic         held = 1'b0, err_chk = 1'b0;
    logic [7:0]   exp_err = 8'd0;
    time          first_t = 0;
    logic [W-1:0] s_res;
    logic [3:0]   s_tag;
    logic         s_err, s_to;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!reset) begin
            held    = 1'b0;
            err_chk = 1'b0;
            exp_err = 8'd0;
        end else begin
            if (err_chk) begin
                chk("err_count", 448'(err_count), 448'(exp_err));
                err_chk = 1'b0;
            end
            if (out_valid) begin
                if (!held) begin
                    first_t = $time;
                end else begin
                    chk("hold result", out_result, s_res);
                    chk("hold tag", 448'(out_tag), 448'(s_tag));
                    chk("hold flags", 448'({out_error, out_timeout}), 448'({s_err, s_to}));
                    chk("hold in_ready", 448'(in_ready), 448'd0);
                end
                s_res = out_result; s_tag = out_tag; s_err = out_error; s_to = out_timeout;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected response: tag %0h result %0h", out_tag, out_result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", out_result, e.res);
                        chk("tag", 448'(out_tag), 448'(e.tag));
                        chk("error", 448'(out_error), 448'(e.err));
                        chk("timeout", 448'(out_timeout), 448'(e.to));
                        if (e.lat > 0) begin
                            lat = int'((first_t - 5 - e.acc_t) / 10) + 1;
                            chk("latency", 448'(lat), 448'(e.lat));
                        end
                        if (e.err && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                        err_chk = 1'b1;
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] tag, input logic push, input logic [W-1:0] eres,
                        input logic eerr, input logic eto, input int elat);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        for (int i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("in_ready before accept", 448'(in_ready), 448'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.res = eres; e.tag = tag; e.err = eerr; e.to = eto; e.lat = elat; e.acc_t = $time;
        if (push) sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        chk("drain", 448'(sb.size()), 448'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd448();
        logic [W-1:0] r;
        for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [W-1:0] big, exp_mul;
        int n, gap, phase;
        logic bad;

        reset = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 448'(in_ready), 448'd0);
        chk("reset out_valid", 448'(out_valid), 448'd0);
        chk("reset enables", 448'({add_en, mul_en}), 448'd0);
        chk("reset err_count", 448'(err_count), 448'd0);
        chk("reset out_result", out_result, 448'd0);
        @(posedge clk); #1 reset = 1'b1;

        // ADD 5+7, also measure the enable gap between passes
        send(2'b00, 448'd5, 448'd7, 4'h1, 1'b1, 448'd12, 1'b0, 1'b0, 9);
        phase = 0; gap = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (phase == 0 && add_en) phase = 1;
            else if (phase == 1 && !add_en) begin phase = 2; gap = 1; end
            else if (phase == 2) begin
                if (add_en) phase = 3;
                else gap++;
            end
        end
        chk("add_en gap", 448'(gap), 448'd1);
        drain();

        // SUB 3-5 = p-2
        send(2'b01, 448'd3, 448'd5, 4'h2, 1'b1, P448 - 448'd2, 1'b0, 1'b0, 9);
        drain();

        // Illegal op: no unit touched, error response two cycles on
        send(2'b11, 448'd9, 448'd9, 4'h3, 1'b1, 448'd0, 1'b1, 1'b0, 2);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (add_en || mul_en) bad = 1'b1;
        end
        chk("illegal no enables", 448'(bad), 448'd0);
        drain();
        chk("err_count after illegal", 448'(err_count), 448'd1);

        // MUL 2^447*3 with corrupted check pass
        big = 448'd1 << 447;
        exp_mul = (448'd1 << 447) | (448'd1 << 224) | 448'd1;
        mul_corrupt = 1'b1;
        send(2'b10, big, 448'd3, 4'h4, 1'b1, exp_mul, 1'b1, 1'b0, 11);
        drain();
        mul_corrupt = 1'b0;

        // Timeout: multiplier never finishes
        mul_stuck = 1'b1;
        send(2'b10, 448'd2, 448'd3, 4'h5, 1'b1, 448'd0, 1'b1, 1'b1, 65);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mul_en) n++;
            else if (n > 0) break;
        end
        chk("mul_en high cycles", 448'(n), 448'd64);
        drain();
        mul_stuck = 1'b0;

        // Next request after timeout completes normally
        send(2'b10, 448'd2, 448'd3, 4'h6, 1'b1, 448'd6, 1'b0, 1'b0, 11);
        drain();

        // Back-pressure: hold out_ready low 10 cycles in HOLD
        @(posedge clk); #1 out_ready = 1'b0;
        send(2'b00, 448'd1, 448'd1, 4'h9, 1'b1, 448'd2, 1'b0, 1'b0, 9);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        chk("stall out_valid", 448'(out_valid), 448'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Reset pulse in RUN1: enables drop at once, no response
        add_lat = 5;
        send(2'b00, 448'd4, 448'd4, 4'hA, 1'b0, 448'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("add_en before reset", 448'(add_en), 448'd1);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        chk("reset enables drop", 448'({add_en, mul_en}), 448'd0);
        chk("reset out_valid mid-op", 448'(out_valid), 448'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no response after reset", 448'(bad), 448'd0);
        add_lat = 3;

        // 300 errored responses saturate the 8-bit counter
        for (int i = 0; i < 300; i++) begin
            send(2'b11, rnd448(), rnd448(), 4'(i), 1'b1, 448'd0, 1'b1, 1'b0, 2);
        end
        drain();
        chk("err_count saturated", 448'(err_count), 448'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
